// File: rtl/delay_sum_pkg.sv
// Shared constants for the delay/sum line: output mode encodings and DEPTH limits.
package delay_sum_pkg;

    localparam logic [1:0] MODE_DELAY = 2'b00;
    localparam logic [1:0] MODE_DADD  = 2'b01;
    localparam logic [1:0] MODE_ACC   = 2'b10;

    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 16;

    // Fill counter must reach DEPTH+1, so it needs room for DEPTH+2 states.
    function automatic int fill_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/delay_sum_line_sat_add.sv
// Combinational signed adder, one guard bit wide, with optional clamp to the signed range.
module sat_add #(
    parameter int WIDTH = 32,
    parameter int SAT   = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    function automatic logic [WIDTH-1:0] saturate(input logic signed [WIDTH:0] s);
        logic [WIDTH-1:0] r;
        r = s[WIDTH-1:0];
        // Guard bit disagreeing with the result MSB means the sum left the WIDTH-bit range.
        if (SAT != 0 && (s[WIDTH] != s[WIDTH-1]))
            r = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return r;
    endfunction

    logic signed [WIDTH:0] sum;

    assign sum = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
    assign y   = saturate(sum);

endmodule

// File: rtl/delay_sum_line.sv
// DEPTH-stage delay line with strobe-edge capture and a registered delay / delay-add / accumulate output.
module delay_sum_line
    import delay_sum_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic [WIDTH-1:0] x_i_porty,
    input  logic             srdyi_i,
    input  logic             sum_en,
    input  logic             sum_rst,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] z_o_portx,
    output logic             z_vld_o
);

    localparam int FILL_W = fill_width(DEPTH);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH + 1);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_check
        $error("delay_sum_line: DEPTH out of range");
    end

    logic signed [WIDTH-1:0] input_reg;
    logic signed [WIDTH-1:0] stage [DEPTH];
    logic signed [WIDTH-1:0] z_q;
    logic                    srdy_q;
    logic [FILL_W-1:0]       fill_cnt;
    logic                    z_vld_q;

    logic signed [WIDTH-1:0] tail;
    logic signed [WIDTH-1:0] z_next;
    logic [WIDTH-1:0]        add_a;
    logic [WIDTH-1:0]        add_b;
    logic [WIDTH-1:0]        add_y;

    // Capture: only the rising edge of the strobe loads a sample; sum_rst leaves it alone.
    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            srdy_q    <= 1'b0;
            input_reg <= '0;
        end else begin
            srdy_q <= srdyi_i;
            if (srdyi_i && !srdy_q)
                input_reg <= x_i_porty;
        end
    end

    // One shared adder: accumulate adds the tail to the output, delay-add adds it to the input.
    always_comb begin
        tail  = stage[DEPTH-1];
        add_a = tail;
        add_b = input_reg;
        if (mode_i == MODE_ACC) begin
            add_a = z_q;
            add_b = tail;
        end
        z_next = tail;
        if (mode_i == MODE_DADD || mode_i == MODE_ACC)
            z_next = add_y;
    end

    sat_add #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_sat_add (
        .a (add_a),
        .b (add_b),
        .y (add_y)
    );

    // Delay line, output register and fill tracking advance together on sum_en.
    always_ff @(posedge clk) begin
        if (!GlobalReset || sum_rst) begin
            for (int k = 0; k < DEPTH; k++)
                stage[k] <= '0;
            z_q      <= '0;
            fill_cnt <= '0;
            z_vld_q  <= 1'b0;
        end else if (sum_en) begin
            stage[0] <= input_reg;
            for (int k = 1; k < DEPTH; k++)
                stage[k] <= stage[k-1];
            z_q <= z_next;
            if (fill_cnt != FILL_FULL)
                fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt >= FILL_W'(DEPTH))
                z_vld_q <= 1'b1;
        end
    end

    assign z_o_portx = z_q;
    assign z_vld_o   = z_vld_q;

endmodule

// File: tb/tb_delay_sum_line.sv
// Directed bench for delay_sum_line across four parameter sets sharing one clock and reset.
module tb_delay_sum_line;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] xa;
    logic        sa, ea, ra;
    logic [1:0]  ma;
    logic [7:0]  xb;
    logic        sb, eb, rb;
    logic [1:0]  mb;

    logic [31:0] za, zd;
    logic        va, vd;
    logic [7:0]  zb, zc;
    logic        vb, vc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    delay_sum_line #(.WIDTH(32), .DEPTH(2), .SAT(1)) dut_a (
        .clk(clk), .GlobalReset(rst_n), .x_i_porty(xa), .srdyi_i(sa), .sum_en(ea),
        .sum_rst(ra), .mode_i(ma), .z_o_portx(za), .z_vld_o(va));

    delay_sum_line #(.WIDTH(32), .DEPTH(3), .SAT(1)) dut_d (
        .clk(clk), .GlobalReset(rst_n), .x_i_porty(xa), .srdyi_i(sa), .sum_en(ea),
        .sum_rst(ra), .mode_i(ma), .z_o_portx(zd), .z_vld_o(vd));

    delay_sum_line #(.WIDTH(8), .DEPTH(1), .SAT(1)) dut_b (
        .clk(clk), .GlobalReset(rst_n), .x_i_porty(xb), .srdyi_i(sb), .sum_en(eb),
        .sum_rst(rb), .mode_i(mb), .z_o_portx(zb), .z_vld_o(vb));

    delay_sum_line #(.WIDTH(8), .DEPTH(1), .SAT(0)) dut_c (
        .clk(clk), .GlobalReset(rst_n), .x_i_porty(xb), .srdyi_i(sb), .sum_en(eb),
        .sum_rst(rb), .mode_i(mb), .z_o_portx(zc), .z_vld_o(vc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        xa = '0; sa = 0; ea = 0; ra = 0; ma = 2'b00;
        xb = '0; sb = 0; eb = 0; rb = 0; mb = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_za", za, 32'd0);
        chk("rst_va", 32'(va), 32'd0);
        chk("rst_inreg_a", dut_a.input_reg, 32'd0);
        chk("rst_zb", 32'(zb), 32'd0);

        // Delay mode, DEPTH=2
        xa = 32'd5; sa = 1; tick();
        sa = 0; ea = 1; tick();
        chk("dly_adv1", za, 32'd0);
        ea = 0; xa = 32'd7; sa = 1; tick();
        sa = 0; ea = 1; tick();
        chk("dly_adv2", za, 32'd0);
        chk("dly_vld_adv2", 32'(va), 32'd0);
        tick();
        chk("dly_adv3", za, 32'd5);
        chk("dly_vld_adv3", 32'(va), 32'd1);
        tick();
        chk("dly_adv4", za, 32'd7);
        ea = 0;

        // Strobe held high captures once
        sa = 1; xa = 32'd1; tick();
        xa = 32'd2; tick();
        xa = 32'd3; tick();
        xa = 32'd4; tick();
        chk("strobe_hold", dut_a.input_reg, 32'd1);
        sa = 0; tick();
        xa = 32'd9; sa = 1; ea = 1; tick();
        chk("cap_adv_stage0_old", dut_a.stage[0], 32'd1);
        chk("cap_adv_inreg", dut_a.input_reg, 32'd9);
        sa = 0; tick();
        chk("cap_adv_stage0_new", dut_a.stage[0], 32'd9);
        ea = 0;

        // Delay-add saturation, WIDTH=8 DEPTH=1
        mb = 2'b01;
        xb = 8'd100; sb = 1; tick();
        sb = 0; eb = 1; tick();
        chk("dadd_first", 32'(zb), 32'd100);
        tick();
        chk("dadd_sat", 32'(zb), 32'h7F);
        chk("dadd_wrap", 32'(zc), 32'hC8);
        eb = 0;

        // Accumulate, DEPTH=1
        do_reset();
        mb = 2'b10;
        xb = 8'd3; sb = 1; tick();
        sb = 0; eb = 1; tick();
        chk("acc_adv1", 32'(zb), 32'd0);
        chk("acc_vld_adv1", 32'(vb), 32'd0);
        eb = 0; xb = 8'd4; sb = 1; tick();
        sb = 0; eb = 1; tick();
        chk("acc_adv2", 32'(zb), 32'd3);
        chk("acc_vld_adv2", 32'(vc), 32'd1);
        eb = 0; xb = 8'd5; sb = 1; tick();
        sb = 0; eb = 1; tick();
        chk("acc_adv3", 32'(zb), 32'd7);
        tick();
        chk("acc_adv4", 32'(zb), 32'd12);
        eb = 0; xb = 8'h9C; sb = 1; tick();
        sb = 0; eb = 1; tick();
        chk("acc_adv5", 32'(zb), 32'd17);
        tick();
        chk("acc_adv6", 32'(zb), 32'hAD);
        tick();
        chk("acc_negsat", 32'(zb), 32'h80);
        chk("acc_negwrap", 32'(zc), 32'h49);
        mb = 2'b11; tick();
        chk("mode11_delay", 32'(zb), 32'h9C);
        eb = 0;

        // sum_rst mid-fill, DEPTH=3
        do_reset();
        ma = 2'b00;
        xa = 32'd11; sa = 1; tick();
        sa = 0; ea = 1; tick();
        tick();
        ra = 1; tick();
        chk("srst_zd", zd, 32'd0);
        chk("srst_vd", 32'(vd), 32'd0);
        chk("srst_stage0", dut_d.stage[0], 32'd0);
        chk("srst_stage1", dut_d.stage[1], 32'd0);
        chk("srst_inreg", dut_d.input_reg, 32'd11);
        ra = 0; tick(); tick(); tick();
        chk("srst_vd_adv3", 32'(vd), 32'd0);
        chk("srst_zd_adv3", zd, 32'd0);
        tick();
        chk("srst_vd_adv4", 32'(vd), 32'd1);
        chk("srst_zd_adv4", zd, 32'd11);
        ea = 0;

        // GlobalReset beats a simultaneous strobe and advance
        do_reset();
        xa = 32'h1234; sa = 1; tick();
        sa = 0; ea = 1; tick(); tick(); tick();
        chk("pre_grst_za", za, 32'h1234);
        chk("pre_grst_va", 32'(va), 32'd1);
        ea = 0; tick();
        rst_n = 0; xa = 32'h55; sa = 1; ea = 1; tick();
        rst_n = 1; sa = 0; ea = 0;
        chk("grst_za", za, 32'd0);
        chk("grst_va", 32'(va), 32'd0);
        chk("grst_inreg", dut_a.input_reg, 32'd0);
        chk("grst_stage0", dut_a.stage[0], 32'd0);
        chk("grst_stage1", dut_a.stage[1], 32'd0);
        chk("grst_srdyq", 32'(dut_a.srdy_q), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
